// File: rtl/mem_issue_unit.sv
// mem_issue_unit: issues one SIMT load/store to a memory controller and returns a single write-back pulse
// Ports: clk, reset (sync, active-high)
//   pipeline side: req_load/req_store pulse, req_en/req_addr/req_data/req_rd request, busy stall
//   write-back:    wb_valid pulse with wb_en, wb_data, wb_rd, wb_err (timeout)
//   controller:    MRead/MWrite command, mc_en/mc_addr/mc_data operands, MReady done, mc_q read data
module mem_issue_unit #(
  parameter int N_CORES = 4,
  parameter int N_CORES_LOG = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [N_CORES-1:0]    req_en,
  input  logic [N_CORES*16-1:0] req_addr,
  input  logic [N_CORES*16-1:0] req_data,
  input  logic [3:0]            req_rd,
  output logic                  busy,
  output logic                  wb_valid,
  output logic [N_CORES-1:0]    wb_en,
  output logic [N_CORES*16-1:0] wb_data,
  output logic [3:0]            wb_rd,
  output logic                  wb_err,
  output logic                  MRead,
  output logic                  MWrite,
  input  logic                  MReady,
  output logic [N_CORES-1:0]    mc_en,
  output logic [N_CORES*16-1:0] mc_addr,
  output logic [N_CORES*16-1:0] mc_data,
  input  logic [N_CORES*16-1:0] mc_q
);
  localparam int W = N_CORES * 16;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_load, r_err;
  logic [N_CORES-1:0] r_en;
  logic [W-1:0] r_addr, r_data, r_wb_data, w_mask;
  logic [3:0] r_rd, r_wb_rd;
  logic [CW-1:0] r_cnt;
  logic w_req, w_ready, w_tmo, w_act;
  if ((1 << N_CORES_LOG) != N_CORES) begin : g_bad_log
    $error("N_CORES_LOG must equal log2(N_CORES)");
  end
  for (genvar g = 0; g < N_CORES; g++) begin : g_mask
    assign w_mask[16*g +: 16] = {16{r_en[g]}};
  end
  assign w_req = req_load ^ req_store;
  // the first WAIT cycle is blanked: the controller may still show ready from its idle state
  assign w_ready = (r_state == WAIT) && MReady && (r_cnt != '0);
  assign w_tmo = (r_state == WAIT) && !w_ready && (r_cnt == CW'(TIMEOUT - 1));
  assign w_act = (r_state == ISSUE) || (r_state == WAIT);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? ((|req_en) ? ISSUE : DONE) : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (w_ready || w_tmo) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_load <= 1'b0;
      r_err <= 1'b0;
      r_en <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_rd <= '0;
      r_wb_rd <= '0;
      r_wb_data <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && w_req) begin
        r_load <= req_load;
        r_en <= req_en;
        r_addr <= req_addr;
        r_data <= req_data;
        r_rd <= req_rd;
        r_err <= 1'b0;
      end
      // wb_rd only changes on entry to DONE so it holds between pulses
      if (w_next == DONE && r_state != DONE) r_wb_rd <= (r_state == IDLE) ? req_rd : r_rd;
      if (w_tmo) begin
        r_err <= 1'b1;
        r_wb_data <= '0;
      end else if (w_ready && r_load) begin
        r_wb_data <= mc_q & w_mask;
      end else if (r_state == IDLE && w_req && req_load && req_en == '0) begin
        r_wb_data <= '0;
      end
    end
  end
  assign busy = r_state != IDLE;
  assign wb_valid = r_state == DONE;
  assign wb_en = (wb_valid && r_load) ? r_en : '0;
  assign wb_err = wb_valid && r_err;
  assign wb_data = r_wb_data;
  assign wb_rd = r_wb_rd;
  assign MRead = (r_state == ISSUE) && r_load;
  assign MWrite = (r_state == ISSUE) && !r_load;
  assign mc_en = w_act ? r_en : '0;
  assign mc_addr = w_act ? r_addr : '0;
  assign mc_data = w_act ? r_data : '0;
endmodule

// File: tb/tb_mem_issue_unit.sv
// tb_mem_issue_unit: randomized self-checking bench for mem_issue_unit against a transaction-level model
module tb_mem_issue_unit;
  localparam int N = 4;
  localparam int W = N * 16;
  localparam int TO = 64;
  logic clk = 0, reset = 1, req_load = 0, req_store = 0, MReady = 0;
  logic [N-1:0] req_en = '0;
  logic [W-1:0] req_addr = '0, req_data = '0, mc_q = '0;
  logic [3:0] req_rd = '0;
  logic busy, wb_valid, wb_err, MRead, MWrite;
  logic [N-1:0] wb_en, mc_en;
  logic [W-1:0] wb_data, mc_addr, mc_data;
  logic [3:0] wb_rd;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int ready_mode = 2, ready_at = -1;
  logic [15:0] mem [int];
  logic [W-1:0] exp_wb_data = '0;
  logic [3:0] exp_wb_rd = '0;

  mem_issue_unit #(.N_CORES(N), .N_CORES_LOG(2), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_load(req_load), .req_store(req_store), .req_en(req_en),
    .req_addr(req_addr), .req_data(req_data), .req_rd(req_rd), .busy(busy), .wb_valid(wb_valid),
    .wb_en(wb_en), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err), .MRead(MRead), .MWrite(MWrite),
    .MReady(MReady), .mc_en(mc_en), .mc_addr(mc_addr), .mc_data(mc_data), .mc_q(mc_q));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : a + 16'd100;
  endfunction

  // controller model: ready timing chosen per transaction (0: pulse at ready_at, 1: held high, 2: never)
  always @(negedge clk) begin
    MReady = (ready_mode == 1) || (ready_mode == 0 && cyc == ready_at);
    for (int i = 0; i < N; i++)
      mc_q[16*i +: 16] = mc_en[i] ? rd_mem(mc_addr[16*i +: 16]) : 16'($urandom);
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic txn(input bit ld, input logic [N-1:0] en, input logic [W-1:0] addr,
                     input logic [W-1:0] data, input logic [3:0] rd, input int mode, input int d,
                     input bit intr);
    int c, wt, done_t;
    bit err, act;
    logic [W-1:0] new_data;
    @(negedge clk);
    c = cyc;
    err = 0;
    wt = 0;
    if (en == '0) done_t = c + 1;
    else begin
      if (mode == 1) wt = 2;
      else if (mode == 0 && d >= 2 && d <= TO) wt = d;
      else begin
        wt = TO;
        err = 1;
      end
      done_t = c + 2 + wt;
    end
    new_data = exp_wb_data;
    if (err) new_data = '0;
    else if (ld) for (int i = 0; i < N; i++) new_data[16*i +: 16] = en[i] ? rd_mem(addr[16*i +: 16]) : 16'd0;
    ready_mode = mode;
    ready_at = c + 1 + d;
    req_load = ld;
    req_store = !ld;
    req_en = en;
    req_addr = addr;
    req_data = data;
    req_rd = rd;
    for (int t = c + 1; t <= done_t + 1; t++) begin
      @(negedge clk);
      req_load = 0;
      req_store = 0;
      if (intr && t == c + 1) begin
        req_load = 1;
        req_en = 4'($urandom);
        req_addr = {$urandom, $urandom};
        req_rd = 4'($urandom);
      end
      act = en != '0 && t <= c + 1 + wt;
      check("busy", busy, t <= done_t);
      check("wb_valid", wb_valid, t == done_t);
      check("mcmd", {MRead, MWrite}, (en != '0 && t == c + 1) ? {ld, !ld} : 2'b00);
      check("mc_bus", {mc_en, mc_addr, mc_data}, act ? {en, addr, data} : '0);
      check("wb_data", wb_data, t < done_t ? exp_wb_data : new_data);
      check("wb_rd", wb_rd, t < done_t ? exp_wb_rd : rd);
      if (t == done_t) begin
        check("wb_en", wb_en, ld ? en : '0);
        check("wb_err", wb_err, err);
      end
    end
    exp_wb_data = new_data;
    exp_wb_rd = rd;
    if (!ld && !err)
      for (int i = 0; i < N; i++) if (en[i]) mem[int'(addr[16*i +: 16])] = data[16*i +: 16];
    ready_mode = 2;
  endtask

  task automatic ignore_both();
    @(negedge clk);
    req_load = 1;
    req_store = 1;
    req_en = 4'hF;
    req_rd = 4'd12;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_load = 0;
      req_store = 0;
      check("both_ignored", {busy, wb_valid, MRead, MWrite, wb_rd}, {4'b0000, exp_wb_rd});
    end
  endtask

  task automatic reset_abort();
    @(negedge clk);
    ready_mode = 2;
    req_load = 1;
    req_en = 4'hF;
    req_addr = {16'd4, 16'd3, 16'd2, 16'd1};
    req_rd = 4'd5;
    repeat (6) begin
      @(negedge clk);
      req_load = 0;
    end
    check("in_wait", {busy, mc_en}, {1'b1, 4'hF});
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst_ctl", {busy, wb_valid, wb_err, MRead, MWrite, wb_en, wb_rd, mc_en}, '0);
    check("rst_bus", {wb_data, mc_addr, mc_data}, '0);
    exp_wb_data = '0;
    exp_wb_rd = '0;
    repeat (4) begin
      @(negedge clk);
      check("no_wb_after_rst", {busy, wb_valid}, 2'b00);
    end
  endtask

  function automatic logic [W-1:0] rnd_addr();
    logic [W-1:0] a;
    for (int i = 0; i < N; i++) a[16*i +: 16] = 16'($urandom_range(0, 31));
    return a;
  endfunction

  initial begin
    logic [W-1:0] a10 = {16'd13, 16'd12, 16'd11, 16'd10};
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, wb_valid, wb_err, MRead, MWrite, wb_en, wb_rd, mc_en}, '0);
    check("reset_bus", {wb_data, mc_addr, mc_data}, '0);
    reset = 0;
    txn(1, 4'b1110, a10, '0, 4'd3, 0, 3, 0);
    check("load_lanes", wb_data, {16'd113, 16'd112, 16'd111, 16'd0});
    txn(0, 4'b1111, a10, {16'd24, 16'd55, 16'd20, 16'd9}, 4'd7, 0, 4, 0);
    txn(1, 4'b1111, a10, '0, 4'd8, 0, 2, 0);
    check("store_readback", wb_data, {16'd24, 16'd55, 16'd20, 16'd9});
    txn(1, 4'b0101, a10, '0, 4'd9, 1, 0, 0);
    txn(1, 4'b1111, a10, '0, 4'd10, 2, 0, 0);
    txn(1, 4'b1011, a10, '0, 4'd11, 0, 1, 0);
    txn(1, 4'b1111, a10, '0, 4'd2, 0, TO, 0);
    txn(0, 4'b0110, rnd_addr(), {$urandom, $urandom}, 4'd4, 0, TO + 1, 0);
    txn(1, 4'b0000, a10, '0, 4'd1, 0, 3, 0);
    txn(0, 4'b0000, a10, {$urandom, $urandom}, 4'd6, 0, 3, 1);
    ignore_both();
    txn(1, 4'b1111, a10, '0, 4'd13, 0, 5, 1);
    reset_abort();
    txn(1, 4'b0011, a10, '0, 4'd14, 0, 3, 0);
    for (int k = 0; k < 40; k++) begin
      int r = $urandom_range(0, 7);
      txn(1'($urandom), 4'($urandom), rnd_addr(), {$urandom, $urandom}, 4'($urandom),
          r < 6 ? 0 : r - 5, $urandom_range(1, 8), $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_issue_unit.md
MEM_ISSUE_UNIT -- requirements
Module: mem_issue_unit

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of SIMT lanes.
REQ-002 SHALL have parameter N_CORES_LOG, default 2, log2(N_CORES).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles waited for MReady.
REQ-004 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: req_load / req_store  in  1 each  one-cycle request pulse from the pipeline.
REQ-007 SHALL have ports: req_en  in  N_CORES  per-lane enable.
REQ-008 SHALL have ports: req_addr / req_data  in  N_CORES*16 each  per-lane address and store data, lane i at bits [16i+15:16i].
REQ-009 SHALL have ports: req_rd  in  4  destination register tag.
REQ-010 SHALL have ports: busy  out  1  pipeline stall.
REQ-011 SHALL have ports: wb_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports: wb_en  out  N_CORES  lanes written back.
REQ-013 SHALL have ports: wb_data  out  N_CORES*16  load results.
REQ-014 SHALL have ports: wb_rd  out  4  tag.
REQ-015 SHALL have ports: wb_err  out  1  timeout flag, valid with wb_valid.
REQ-016 SHALL have ports: MRead / MWrite  out  1 each  memory controller command.
REQ-017 SHALL have ports: MReady  in  1  controller done.
REQ-018 SHALL have ports: mc_en  out  N_CORES  controller lane enables.
REQ-019 SHALL have ports: mc_addr / mc_data  out  N_CORES*16 each  controller lane operands.
REQ-020 SHALL have ports: mc_q  in  N_CORES*16  controller lane read data.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: on exactly one of req_load/req_store high, latch req_en, req_addr, req_data, req_rd and operation type; go to ISSUE.
REQ-023 IDLE with req_en == 0 on a valid request: skip ISSUE/WAIT, go straight to DONE; no MRead/MWrite issued.
REQ-024 req_load and req_store both high in IDLE: request ignored; stay IDLE; no pulse.
REQ-025 ISSUE: drive MRead (load) or MWrite (store) high for exactly one cycle; go to WAIT.
REQ-026 mc_en, mc_addr, mc_data SHALL equal the latched values from ISSUE through the last WAIT cycle; 0 otherwise.
REQ-027 WAIT: first WAIT cycle ignores MReady (blanking: controller may still show idle-ready); from second cycle on, MReady==1 completes.
REQ-028 On completion of a load, capture mc_q for enabled lanes into wb_data; disabled lanes' wb_data = 0.
REQ-029 WAIT SHALL count cycles; if TIMEOUT cycles elapse without qualifying MReady, go to DONE with wb_err=1 and wb_data all 0.
REQ-030 DONE: wb_valid=1 for one cycle, wb_en = latched enables (load only; all-zero for store), wb_rd = latched tag; then IDLE.
REQ-031 busy SHALL be 1 in ISSUE, WAIT, DONE; 0 in IDLE; request-to-wb_valid latency = 3 + (WAIT cycles).
REQ-032 Requests arriving while busy SHALL be ignored without altering latched state.
REQ-033 wb_data/wb_rd SHALL hold their last values between wb_valid pulses.

Reset
REQ-034 reset SHALL force IDLE, clear latches and timeout counter.
REQ-035 reset SHALL drive busy, wb_valid, wb_err, MRead, MWrite to 0.
REQ-036 reset SHALL drive wb_en, wb_data, wb_rd, mc_en, mc_addr, mc_data to 0.
REQ-037 reset asserted mid-operation SHALL abort immediately, with no wb_valid for the aborted request.

Verification
REQ-038 Load: en=4'b1110, addr lanes 1..3 = 11,12,13; model returns q=addr+100 with MReady three cycles after MRead -> one MRead pulse, wb_valid once, wb_en=1110, wb_data lanes = 0,111,112,113.
REQ-039 Store: en=4'b1111, data 9,20,55,24 -> one MWrite pulse, mc_data stable until MReady; wb_valid with wb_en=0; memory holds 9,20,55,24 at addresses 10..13.
REQ-040 MReady held high from idle: WAIT not exited on first WAIT cycle; completion on second WAIT cycle.
REQ-041 MReady never asserted -> wb_valid with wb_err=1 after TIMEOUT=64 WAIT cycles; busy drops next cycle.
REQ-042 Edge cases: req_en=0 -> wb_valid 2 cycles after request with no MRead; req_load+req_store together -> busy stays 0; request during busy -> ignored.
REQ-043 Reset mid-WAIT -> all outputs 0 next cycle, no wb_valid; next request completes normally.
